// File: rtl/updn_sequencer.sv
// updn_sequencer
// Run-control sequencer for a WIDTH-bit up/down counter with load, enable
// and direction inputs. It holds a programmed range and mode, divides the
// clock into count ticks, and drives the counter's load/enable/direction
// strobes. It watches the counter value to decide when to stop, reverse
// or wrap.
//
// Ports
//   CLK           system clock, rising edge
//   RST           asynchronous active-low reset
//   CFG_WE        config write strobe (taken only while idle, also clears ERR)
//   CFG_MODE      00 single-up, 01 single-down, 10 ping-pong, 11 wrap-up
//   CFG_LO/HI     range bounds
//   CFG_DIV       tick period minus one
//   START/STOP    run control, level-sampled; STOP has priority
//   CNT_VAL       current counter output
//   CNT_EN        counter step enable
//   CNT_UP        step direction (1 = increment)
//   CNT_LOAD      load CNT_LOAD_VAL into the counter
//   CNT_LOAD_VAL  load value
//   BUSY          sequencer not idle
//   DONE          one-cycle pulse at normal end of a single-direction run
//   WRAP          one-cycle pulse at each reversal or wrap
//   ERR           sticky: START attempted with LO > HI
module updn_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [1:0]       CFG_MODE,
  input  logic [WIDTH-1:0] CFG_LO,
  input  logic [WIDTH-1:0] CFG_HI,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] CNT_VAL,
  output logic             CNT_EN,
  output logic             CNT_UP,
  output logic             CNT_LOAD,
  output logic [WIDTH-1:0] CNT_LOAD_VAL,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRAP,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [1:0]       MODE_UP   = 2'b00;
  localparam logic [1:0]       MODE_DN   = 2'b01;
  localparam logic [1:0]       MODE_PP   = 2'b10;
  localparam logic [1:0]       MODE_WRAP = 2'b11;
  localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic             tick_s;
  logic             at_hi_s;
  logic             at_lo_s;
  logic             cnt_en_s;
  logic             cnt_up_s;
  logic             cnt_load_s;
  logic [WIDTH-1:0] load_val_s;
  logic             done_s;
  logic             wrap_s;

  assign tick_s  = (presc_q == div_q);
  assign at_hi_s = (CNT_VAL == hi_q);
  assign at_lo_s = (CNT_VAL == lo_q);

  // Next-state, config capture and strobe decode.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    div_d      = div_q;
    presc_d    = presc_q;
    dir_d      = dir_q;
    err_d      = err_q;
    cnt_en_s   = 1'b0;
    cnt_up_s   = 1'b0;
    cnt_load_s = 1'b0;
    load_val_s = '0;
    done_s     = 1'b0;
    wrap_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (CFG_WE) begin
          mode_d = CFG_MODE;
          lo_d   = CFG_LO;
          hi_d   = CFG_HI;
          div_d  = CFG_DIV;
          err_d  = 1'b0;
        end else begin
          err_d  = err_q;
        end
        // A rejected START uses the range already held, not one being written now.
        if (START && !STOP) begin
          if (lo_q <= hi_q) begin
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        presc_d = '0;
        if (STOP) begin
          state_d = S_IDLE;
        end else begin
          cnt_load_s = 1'b1;
          load_val_s = (mode_q == MODE_DN) ? hi_q : lo_q;
          dir_d      = (mode_q != MODE_DN);
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (STOP) begin
          presc_d = '0;
          state_d = S_IDLE;
        end else begin
          presc_d = tick_s ? '0 : (presc_q + PRESC_ONE);
          if (tick_s) begin
            case (mode_q)
              MODE_UP: begin
                if (at_hi_s) begin
                  state_d = S_FINISH;
                end else begin
                  cnt_en_s = 1'b1;
                  cnt_up_s = 1'b1;
                end
              end
              MODE_DN: begin
                if (at_lo_s) begin
                  state_d = S_FINISH;
                end else begin
                  cnt_en_s = 1'b1;
                  cnt_up_s = 1'b0;
                end
              end
              MODE_PP: begin
                // Degenerate one-value range: nothing to bounce between, so hold.
                if (at_hi_s && at_lo_s) begin
                  cnt_en_s = 1'b0;
                end else if (dir_q && at_hi_s) begin
                  dir_d    = 1'b0;
                  wrap_s   = 1'b1;
                  cnt_en_s = 1'b1;
                  cnt_up_s = 1'b0;
                end else if (!dir_q && at_lo_s) begin
                  dir_d    = 1'b1;
                  wrap_s   = 1'b1;
                  cnt_en_s = 1'b1;
                  cnt_up_s = 1'b1;
                end else begin
                  cnt_en_s = 1'b1;
                  cnt_up_s = dir_q;
                end
              end
              MODE_WRAP: begin
                if (at_hi_s) begin
                  cnt_load_s = 1'b1;
                  load_val_s = lo_q;
                  wrap_s     = 1'b1;
                end else begin
                  cnt_en_s = 1'b1;
                  cnt_up_s = 1'b1;
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end else begin
            cnt_en_s = 1'b0;
          end
        end
      end

      S_FINISH: begin
        presc_d = '0;
        state_d = S_IDLE;
        if (STOP) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // State, configuration, prescaler, direction and error registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      lo_q    <= '0;
      hi_q    <= '1;
      div_q   <= '0;
      presc_q <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign CNT_EN       = cnt_en_s;
  assign CNT_UP       = cnt_up_s;
  assign CNT_LOAD     = cnt_load_s;
  assign CNT_LOAD_VAL = load_val_s;
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = done_s;
  assign WRAP         = wrap_s;
  assign ERR          = err_q;

endmodule
